mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage sitting between the EX/MEM pipeline register and the MEM/WB register of the 5-stage MIPS core. It performs loads and stores over a req/ack data-memory handshake, formats load data, and passes through the ALU result and HI/LO writes. While an access is outstanding it drives stall_req, which the pipeline controller turns into is_hold for the upstream registers.

Parameters:
DATA_WIDTH, 32, register/memory data width
ADDR_WIDTH, 32, data-memory byte address width
REG_ADDR_WIDTH, 5, register-file address width
TIMEOUT, 16, max BUSY cycles without mem_ack before bus error (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
target_MEM  in  REG_ADDR_WIDTH  destination register
data_in_MEM  in  DATA_WIDTH  ALU result; byte address when ReadMem/WriteMem
rdata_2_MEM  in  DATA_WIDTH  store data
mem_op_MEM  in  3  [1:0] size 00=byte 01=half 10=word (11 treated as word); [2]=1 zero-extend load
WriteReg_MEM, MemOrAlu_MEM, WriteMem_MEM, ReadMem_MEM  in  1 each  controls from EX/MEM
we_hi_MEM, we_lo_MEM  in  1 each;  hi_MEM, lo_MEM  in  DATA_WIDTH each  HI/LO pass-through
mem_req  out  1  access request (registered)
mem_we  out  1  1=store (registered)
mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits 0 (registered)
mem_wdata  out  DATA_WIDTH  lane-replicated store data (registered)
mem_be  out  4  byte enables (registered)
mem_ack  in  1  access complete; mem_rdata valid same cycle
mem_rdata  in  DATA_WIDTH  read word
stall_req  out  1  hold upstream pipeline
target_WB  out  REG_ADDR_WIDTH;  wb_data_WB  out  DATA_WIDTH;  WriteReg_WB  out  1
we_hi_WB, we_lo_WB  out  1 each;  hi_WB, lo_WB  out  DATA_WIDTH each
addr_err  out  1  misaligned access (combinational)
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=0, async): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, load register, timeout counter, bus_err = 0. Combinational outputs follow inputs.
- access = (ReadMem_MEM | WriteMem_MEM) & ~addr_err. If both read and write set, treat as store.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> addr_err=1, no request, no stall, WriteReg_WB=0, we_hi/we_lo forwarded unchanged.
- FSM:
  IDLE: stall_req=access. On edge with access: latch addr/we/be/wdata, mem_req<=1, counter<=0, ->BUSY.
  BUSY: stall_req=1; request fields held stable. Edge with mem_ack=1: capture formatted load data, mem_req<=0, ->DONE. Edge without ack: counter+1; if counter==TIMEOUT-1: mem_req<=0, bus_err<=1 (one cycle), load register<=0, ->DONE.
  DONE: stall_req=0, outputs use captured data; pipeline advances on this edge; ->IDLE unconditionally.
- mem_ack in IDLE/DONE ignored. Zero-wait memory (ack in first BUSY cycle): instruction occupies MEM 3 cycles (2 stall).
- Store lanes (little-endian): byte be=1<<addr[1:0], wdata={4{rdata_2[7:0]}}; half be=addr[1]?1100:0011, wdata={2{rdata_2[15:0]}}; word be=1111, wdata=rdata_2.
- Load: select lane by addr[1:0]; sign- or zero-extend per mem_op[2]; word ignores mem_op[2].
- wb_data_WB = (MemOrAlu_MEM & ReadMem_MEM) ? load register : data_in_MEM. WriteReg_WB = WriteReg_MEM & ~addr_err & ~(state!=DONE & access); a load timing out writes 0.
- target/hi/lo/we_hi/we_lo pass through combinationally.
- Reset mid-access: mem_req drops immediately, FSM to IDLE; no partial result.

Test Plan:
- Non-memory op: data_in=0x1234, WriteReg=1 -> wb_data=0x1234, stall_req=0, mem_req never 1.
- LB addr 0x103, mem_rdata=0x80AABBCC, ack first BUSY cycle -> mem_addr=0x100, be=1111 ignored by read, stall_req 2 cycles, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, rdata_2=0xDEADBEEF, ack after 3 wait cycles -> mem_we=1, be=1100, wdata=0xBEEFBEEF, stall_req 5 cycles, WriteReg_WB=0.
- LW addr 0x301 -> addr_err=1, no mem_req, stall_req=0, WriteReg_WB=0.
- LW, mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles, bus_err pulse 1 cycle, wb_data=0, stall released in DONE.
- rst low during BUSY -> mem_req=0 same cycle, state IDLE; after release a new SW completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory req/ack handshake for loads and
// stores, formats load data and forwards ALU/HI/LO results toward MEM/WB.
//
// state | meaning
// IDLE  | no access outstanding; an aligned load/store launches a request
// BUSY  | request on the bus, waiting for mem_ack or timeout
// DONE  | result captured; pipeline advances on this edge
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] target_MEM,
  input  logic [DATA_WIDTH-1:0]     data_in_MEM,
  input  logic [DATA_WIDTH-1:0]     rdata_2_MEM,
  input  logic [2:0]                mem_op_MEM,
  input  logic                      WriteReg_MEM,
  input  logic                      MemOrAlu_MEM,
  input  logic                      WriteMem_MEM,
  input  logic                      ReadMem_MEM,
  input  logic                      we_hi_MEM,
  input  logic                      we_lo_MEM,
  input  logic [DATA_WIDTH-1:0]     hi_MEM,
  input  logic [DATA_WIDTH-1:0]     lo_MEM,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [3:0]                mem_be,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      stall_req,
  output logic [REG_ADDR_WIDTH-1:0] target_WB,
  output logic [DATA_WIDTH-1:0]     wb_data_WB,
  output logic                      WriteReg_WB,
  output logic                      we_hi_WB,
  output logic                      we_lo_WB,
  output logic [DATA_WIDTH-1:0]     hi_WB,
  output logic [DATA_WIDTH-1:0]     lo_WB,
  output logic                      addr_err,
  output logic                      bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] load_q;

  logic [1:0]            off;
  logic                  is_byte, is_half, zext, access;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata, ld_fmt;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;

  assign off     = data_in_MEM[1:0];
  assign is_byte = (mem_op_MEM[1:0] == 2'b00);
  assign is_half = (mem_op_MEM[1:0] == 2'b01);
  assign zext    = mem_op_MEM[2];

  assign addr_err = (ReadMem_MEM | WriteMem_MEM) &
                    ((is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00)));
  assign access   = (ReadMem_MEM | WriteMem_MEM) & ~addr_err;

  // Store data is replicated across all lanes; byte enables pick the target.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rdata_2_MEM;
    if (is_byte) begin
      st_be    = 4'b0001 << off;
      st_wdata = {4{rdata_2_MEM[7:0]}};
    end else if (is_half) begin
      st_be    = off[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{rdata_2_MEM[15:0]}};
    end
  end

  always_comb begin
    case (off)
      2'd0:    ld_b = mem_rdata[7:0];
      2'd1:    ld_b = mem_rdata[15:8];
      2'd2:    ld_b = mem_rdata[23:16];
      default: ld_b = mem_rdata[31:24];
    endcase
    ld_h = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (is_byte)
      ld_fmt = {{(DATA_WIDTH-8){~zext & ld_b[7]}}, ld_b};
    else if (is_half)
      ld_fmt = {{(DATA_WIDTH-16){~zext & ld_h[15]}}, ld_h};
    else
      ld_fmt = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      tmo_cnt   <= '0;
      load_q    <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            mem_req   <= 1'b1;
            mem_we    <= WriteMem_MEM;
            mem_addr  <= {data_in_MEM[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= WriteMem_MEM ? st_be : 4'b1111;
            mem_wdata <= st_wdata;
            tmo_cnt   <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            load_q  <= ld_fmt;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            // A timed-out load retires with zero rather than stale data.
            load_q  <= '0;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      IDLE:    stall_req = access;
      BUSY:    stall_req = 1'b1;
      default: stall_req = 1'b0;
    endcase
  end

  assign wb_data_WB  = (MemOrAlu_MEM & ReadMem_MEM) ? load_q : data_in_MEM;
  assign WriteReg_WB = WriteReg_MEM & ~addr_err & ~((state != DONE) & access);
  assign target_WB   = target_MEM;
  assign we_hi_WB    = we_hi_MEM;
  assign we_lo_WB    = we_lo_MEM;
  assign hi_WB       = hi_MEM;
  assign lo_WB       = lo_MEM;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected results are queued when an op is
// driven and compared in the cycle the stage releases it.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  target_MEM;
  logic [31:0] data_in_MEM, rdata_2_MEM, hi_MEM, lo_MEM;
  logic [2:0]  mem_op_MEM;
  logic        WriteReg_MEM, MemOrAlu_MEM, WriteMem_MEM, ReadMem_MEM;
  logic        we_hi_MEM, we_lo_MEM;
  logic        mem_req, mem_we, mem_ack, stall_req;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [4:0]  target_WB;
  logic [31:0] wb_data_WB, hi_WB, lo_WB;
  logic        WriteReg_WB, we_hi_WB, we_lo_WB, addr_err, bus_err;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .target_MEM(target_MEM), .data_in_MEM(data_in_MEM), .rdata_2_MEM(rdata_2_MEM),
    .mem_op_MEM(mem_op_MEM), .WriteReg_MEM(WriteReg_MEM), .MemOrAlu_MEM(MemOrAlu_MEM),
    .WriteMem_MEM(WriteMem_MEM), .ReadMem_MEM(ReadMem_MEM),
    .we_hi_MEM(we_hi_MEM), .we_lo_MEM(we_lo_MEM), .hi_MEM(hi_MEM), .lo_MEM(lo_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_req(stall_req),
    .target_WB(target_WB), .wb_data_WB(wb_data_WB), .WriteReg_WB(WriteReg_WB),
    .we_hi_WB(we_hi_WB), .we_lo_WB(we_lo_WB), .hi_WB(hi_WB), .lo_WB(lo_WB),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic        chk_wb;
    logic        wr;
    int          stalls;
    int          reqs;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        berr;
    logic        aerr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[off*8 +: 8];
    h = w[off[1]*16 +: 16];
    case (op[1:0])
      2'b00:   return op[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return op[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  task automatic clear_inputs();
    ReadMem_MEM = 0; WriteMem_MEM = 0; WriteReg_MEM = 0; MemOrAlu_MEM = 0;
    mem_op_MEM = 3'b000; data_in_MEM = 0; rdata_2_MEM = 0; mem_ack = 0;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  // wait_n < 0 means memory never acknowledges.
  task automatic run_op(input string name, input logic rd, input logic wr, input logic wreg,
                        input logic moa, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] rd2, input logic [31:0] rdata, input int wait_n);
    exp_t e, g;
    logic acc;
    logic [1:0] off;
    int b, stalls, cyc;
    bit done, first;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    off    = addr[1:0];
    e.aerr = (rd | wr) & (((op[1:0] == 2'b01) && off[0]) || (op[1:0][1] && off != 2'b00));
    acc    = (rd | wr) & ~e.aerr;
    e.reqs   = acc ? ((wait_n < 0) ? 16 : wait_n + 1) : 0;
    e.stalls = acc ? e.reqs + 1 : 0;
    e.berr   = acc && (wait_n < 0);
    e.wr     = wreg & ~e.aerr;
    e.chk_wb = !((moa & rd) && !acc);
    e.wb     = (moa & rd) ? ((wait_n < 0) ? 32'h0 : exp_load(rdata, off, op)) : addr;
    e.addr   = {addr[31:2], 2'b00};
    e.we     = wr;
    case (op[1:0])
      2'b00:   begin e.be = 4'b0001 << off;                  e.wdata = {4{rd2[7:0]}};  end
      2'b01:   begin e.be = off[1] ? 4'b1100 : 4'b0011;      e.wdata = {2{rd2[15:0]}}; end
      default: begin e.be = 4'b1111;                         e.wdata = rd2;            end
    endcase
    if (!wr) e.be = 4'b1111;
    sb.push_back(e);

    ReadMem_MEM = rd; WriteMem_MEM = wr; WriteReg_MEM = wreg; MemOrAlu_MEM = moa;
    mem_op_MEM = op; data_in_MEM = addr; rdata_2_MEM = rd2; mem_rdata = rdata;

    b = 0; stalls = 0; cyc = 0; done = 0; first = 1;
    o_addr = 0; o_wdata = 0; o_be = 0; o_we = 0;
    while (!done && cyc < 200) begin
      if (mem_req) begin
        if (b == 0) begin o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we; end
        mem_ack = (b == wait_n);
        b++;
      end else begin
        mem_ack = 0;
      end
      @(negedge clk);
      if (stall_req) begin
        stalls++;
        if (first) chk({name, " wr_held"}, WriteReg_WB, 0);
        first = 0;
        @(posedge clk); #1;
      end else begin
        done = 1;
      end
      cyc++;
    end
    chk({name, " released"}, done, 1);

    g = sb.pop_front();
    chk({name, " stalls"}, stalls, g.stalls);
    chk({name, " req_cycles"}, b, g.reqs);
    chk({name, " addr_err"}, addr_err, g.aerr);
    chk({name, " bus_err"}, bus_err, g.berr);
    chk({name, " write_reg"}, WriteReg_WB, g.wr);
    if (g.chk_wb) chk({name, " wb_data"}, wb_data_WB, g.wb);
    if (g.reqs > 0) begin
      chk({name, " mem_addr"}, o_addr, g.addr);
      chk({name, " mem_we"}, o_we, g.we);
      chk({name, " mem_be"}, o_be, g.be);
      if (g.we) chk({name, " mem_wdata"}, o_wdata, g.wdata);
    end

    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk({name, " bus_err_after"}, bus_err, 0);
    chk({name, " req_after"}, mem_req, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    mem_rdata = 0;
    target_MEM = 5'd7; hi_MEM = 32'h1111_2222; lo_MEM = 32'h3333_4444;
    we_hi_MEM = 1; we_lo_MEM = 0;
    #23;
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst stall", stall_req, 0);
    chk("pass target", target_WB, 5'd7);
    chk("pass hi", hi_WB, 32'h1111_2222);
    chk("pass lo", lo_WB, 32'h3333_4444);
    chk("pass we_hi", we_hi_WB, 1);
    chk("pass we_lo", we_lo_WB, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    //      name    rd wr wr moa op      addr          rd2           rdata         wait
    run_op("alu",   0, 0, 1, 0, 3'b010, 32'h0000_1234, 32'h0,        32'h0,         0);
    run_op("lb",    1, 0, 1, 1, 3'b000, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 0);
    run_op("lbu",   1, 0, 1, 1, 3'b100, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 0);
    run_op("sh",    0, 1, 0, 0, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0,        3);
    run_op("lw_mis",1, 0, 1, 1, 3'b010, 32'h0000_0301, 32'h0,        32'h0,         0);
    run_op("lh_mis",1, 0, 1, 1, 3'b001, 32'h0000_0305, 32'h0,        32'h0,         0);
    run_op("lw_tmo",1, 0, 1, 1, 3'b010, 32'h0000_0500, 32'h0,        32'h0,        -1);
    run_op("lh",    1, 0, 1, 1, 3'b001, 32'h0000_0102, 32'h0,        32'h9234_5678, 1);
    run_op("lhu",   1, 0, 1, 1, 3'b101, 32'h0000_0102, 32'h0,        32'h9234_5678, 2);
    run_op("lw",    1, 0, 1, 1, 3'b110, 32'h0000_0304, 32'h0,        32'hCAFE_F00D, 1);
    run_op("sb",    0, 1, 0, 0, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,        0);
    run_op("sw11",  0, 1, 0, 0, 3'b011, 32'h0000_0708, 32'h1357_9BDF, 32'h0,        2);
    run_op("rdwr",  1, 1, 0, 0, 3'b010, 32'h0000_0800, 32'h2468_ACE0, 32'h0,        0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic        w;
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = $urandom;
      if (op[1:0] == 2'b01) a[0] = 1'b0;
      if (op[1]) a[1:0] = 2'b00;
      run_op("rand", ~w, w, ~w, ~w, op, a, $urandom, $urandom, $urandom_range(0, 3));
    end

    // Reset while an access is in flight.
    ReadMem_MEM = 1; MemOrAlu_MEM = 1; WriteReg_MEM = 1; mem_op_MEM = 3'b010;
    data_in_MEM = 32'h0000_0400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid req_before", mem_req, 1);
    rst = 0;
    #1;
    chk("mid req_drop", mem_req, 0);
    chk("mid bus_err", bus_err, 0);
    clear_inputs();
    #1;
    chk("mid stall_idle", stall_req, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    run_op("sw_post", 0, 1, 0, 0, 3'b010, 32'h0000_0404, 32'hA5A5_5A5A, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
